// File: rtl/branch_unit_bht_if.sv
// Fetch-predict and execute-resolve signal bundle for branch_unit_bht.
// The slave modport is the branch unit; the master side is the surrounding pipeline.
interface branch_unit_bht_if #(
    parameter int XLEN = 32
);
    logic            f_req;
    logic [XLEN-1:0] f_pc;
    logic            p_valid;
    logic            p_taken;
    logic            flush;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [2:0]      r_branch;
    logic            r_less;
    logic            r_zero;
    logic            r_pred_taken;

    logic            o_valid;
    logic            o_taken;
    logic            o_pcasrc;
    logic            o_pcbsrc;
    logic            o_mispred;
    logic [XLEN-1:0] mispred_cnt;

    modport slave (
        input  f_req, f_pc, flush,
        input  r_valid, r_pc, r_branch, r_less, r_zero, r_pred_taken,
        output p_valid, p_taken,
        output o_valid, o_taken, o_pcasrc, o_pcbsrc, o_mispred, mispred_cnt
    );

    modport master (
        output f_req, f_pc, flush,
        output r_valid, r_pc, r_branch, r_less, r_zero, r_pred_taken,
        input  p_valid, p_taken,
        input  o_valid, o_taken, o_pcasrc, o_pcbsrc, o_mispred, mispred_cnt
    );
endinterface

// File: rtl/branch_unit_bht.sv
// Branch resolver with registered PC-adder selects plus a PC-indexed table of
// saturating counters that predicts direction for fetch and counts mispredicts.
module branch_unit_bht #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    branch_unit_bht_if.slave  bus
);
    localparam int              DEPTH    = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    logic [CNT_W-1:0] cnt_q [DEPTH];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] r_idx;
    logic             res_taken;
    logic             res_asrc;
    logic             res_bsrc;
    logic             res_mispred;
    logic             tbl_update;

    assign f_idx = bus.f_pc[IDX_W+1:2];
    assign r_idx = bus.r_pc[IDX_W+1:2];

    // PC bits outside the index field never select a counter.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.f_pc[XLEN-1:IDX_W+2], bus.f_pc[1:0],
                              bus.r_pc[XLEN-1:IDX_W+2], bus.r_pc[1:0]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        res_taken = 1'b0;
        res_asrc  = 1'b0;
        res_bsrc  = 1'b0;
        case (bus.r_branch)
            BR_JAL: begin
                res_taken = 1'b1;
                res_asrc  = 1'b1;
            end
            BR_JALR: begin
                res_taken = 1'b1;
                res_asrc  = 1'b1;
                res_bsrc  = 1'b1;
            end
            BR_BEQ, BR_BNE: begin
                res_taken = bus.r_branch[0] ^ bus.r_zero;
                res_asrc  = res_taken;
            end
            BR_BLT, BR_BGE: begin
                res_taken = bus.r_branch[0] ^ bus.r_less;
                res_asrc  = res_taken;
            end
            default: ;
        endcase
    end

    assign res_mispred = bus.r_valid & (res_taken != bus.r_pred_taken);
    assign tbl_update  = bus.r_valid & bus.r_branch[2];

    // Prediction reads the current array contents, so a same-index update this
    // cycle is seen only by later fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.p_valid <= 1'b0;
            bus.p_taken <= 1'b0;
        end else begin
            bus.p_valid <= bus.f_req & ~bus.flush;
            bus.p_taken <= bus.f_req & cnt_q[f_idx][CNT_W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_valid     <= 1'b0;
            bus.o_taken     <= 1'b0;
            bus.o_pcasrc    <= 1'b0;
            bus.o_pcbsrc    <= 1'b0;
            bus.o_mispred   <= 1'b0;
            bus.mispred_cnt <= '0;
        end else begin
            bus.o_valid   <= bus.r_valid;
            bus.o_taken   <= bus.r_valid & res_taken;
            bus.o_pcasrc  <= bus.r_valid & res_asrc;
            bus.o_pcbsrc  <= bus.r_valid & res_bsrc;
            bus.o_mispred <= res_mispred;
            if (res_mispred) begin
                bus.mispred_cnt <= bus.mispred_cnt + XLEN'(1);
            end
        end
    end

    // NOTE: the counter array lives in flops rather than RAM because every entry must return to weakly-not-taken on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (tbl_update) begin
            if (res_taken && cnt_q[r_idx] != CNT_MAX) begin
                cnt_q[r_idx] <= cnt_q[r_idx] + CNT_ONE;
            end else if (!res_taken && cnt_q[r_idx] != CNT_ZERO) begin
                cnt_q[r_idx] <= cnt_q[r_idx] - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_branch_unit_bht.sv
// Self-checking bench for branch_unit_bht: directed scenarios plus random traffic
// compared against a table-of-integers reference model.
module tb_branch_unit_bht;
    localparam int XLEN     = 32;
    localparam int IDX_W    = 6;
    localparam int CNT_W    = 2;
    localparam int DEPTH    = 64;
    localparam int CNT_MAX  = 3;
    localparam int CNT_INIT = 1;
    localparam int TAKEN_AT = 2;

    logic clk = 1'b0;
    logic rst;

    branch_unit_bht_if #(.XLEN(XLEN)) bus ();

    branch_unit_bht #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int              model_cnt [DEPTH];
    logic [XLEN-1:0] model_mcnt;
    logic [6:0]      exp_vec;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    // {p_valid, p_taken, o_valid, o_taken, o_pcasrc, o_pcbsrc, o_mispred}
    function automatic logic [6:0] obs();
        return {bus.p_valid, bus.p_taken, bus.o_valid, bus.o_taken,
                bus.o_pcasrc, bus.o_pcbsrc, bus.o_mispred};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_cnt[i] = CNT_INIT;
        model_mcnt = '0;
    endtask

    task automatic set_inputs(input logic fr, input logic [31:0] fpc, input logic fl,
                              input logic rv, input logic [31:0] rpc, input logic [2:0] rb,
                              input logic rl, input logic rz, input logic rp);
        bus.f_req = fr; bus.f_pc = fpc; bus.flush = fl;
        bus.r_valid = rv; bus.r_pc = rpc; bus.r_branch = rb;
        bus.r_less = rl; bus.r_zero = rz; bus.r_pred_taken = rp;
    endtask

    // Applies one cycle of stimulus, works out what the next edge must produce
    // from the model, advances the model and steps to 1 time unit past the edge.
    task automatic drive(input logic fr, input logic [31:0] fpc, input logic fl,
                         input logic rv, input logic [31:0] rpc, input logic [2:0] rb,
                         input logic rl, input logic rz, input logic rp);
        logic taken, asrc, bsrc, mis;
        int   ri;
        set_inputs(fr, fpc, fl, rv, rpc, rb, rl, rz, rp);
        taken = 1'b0; asrc = 1'b0; bsrc = 1'b0;
        case (rb)
            3'd1: begin taken = 1'b1; asrc = 1'b1; end
            3'd2: begin taken = 1'b1; asrc = 1'b1; bsrc = 1'b1; end
            3'd4: taken = rz;
            3'd5: taken = !rz;
            3'd6: taken = rl;
            3'd7: taken = !rl;
            default: taken = 1'b0;
        endcase
        if (rb >= 3'd4) asrc = taken;
        mis = rv && (taken != rp);
        exp_vec = {fr && !fl, fr && (model_cnt[idx_of(fpc)] >= TAKEN_AT),
                   rv, rv && taken, rv && asrc, rv && bsrc, mis};
        if (mis) model_mcnt = model_mcnt + 1;
        if (rv && rb >= 3'd4) begin
            ri = idx_of(rpc);
            if (taken) model_cnt[ri] = (model_cnt[ri] < CNT_MAX) ? model_cnt[ri] + 1 : CNT_MAX;
            else       model_cnt[ri] = (model_cnt[ri] > 0) ? model_cnt[ri] - 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [2:0] rb,
                           input logic rl, input logic rz, input logic rp);
        drive(1'b0, 32'h0, 1'b0, 1'b1, pc, rb, rl, rz, rp);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        checks++; if (obs() !== 7'b0) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs(), 7'b0); end
        checks++; if (bus.mispred_cnt !== '0) begin errors++; $display("FAIL reset_mcnt: got %0d want 0", bus.mispred_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        fetch(32'h8000_0000);
        checks++; if (obs() !== 7'b1000000) begin errors++; $display("FAIL first_predict: got %b want %b", obs(), 7'b1000000); end
        checks++; if (bus.mispred_cnt !== '0) begin errors++; $display("FAIL first_mcnt: got %0d want 0", bus.mispred_cnt); end
    endtask

    task automatic test_train();
        resolve(32'h8000_0010, 3'b100, 1'b0, 1'b1, 1'b0);
        checks++; if (obs() !== 7'b0011101) begin errors++; $display("FAIL beq_taken_1: got %b want %b", obs(), 7'b0011101); end
        resolve(32'h8000_0010, 3'b100, 1'b0, 1'b1, 1'b0);
        checks++; if (obs() !== 7'b0011101) begin errors++; $display("FAIL beq_taken_2: got %b want %b", obs(), 7'b0011101); end
        checks++; if (bus.mispred_cnt !== 32'd2) begin errors++; $display("FAIL mcnt_after_two: got %0d want 2", bus.mispred_cnt); end
        resolve(32'h8000_0010, 3'b100, 1'b0, 1'b1, 1'b1);
        checks++; if (obs() !== 7'b0011100) begin errors++; $display("FAIL beq_taken_predicted: got %b want %b", obs(), 7'b0011100); end
        fetch(32'h8000_0010);
        checks++; if (obs() !== 7'b1100000) begin errors++; $display("FAIL trained_predict: got %b want %b", obs(), 7'b1100000); end
        // Two not-taken from a saturated 11 must land on 01, never wrap.
        resolve(32'h8000_0010, 3'b100, 1'b0, 1'b0, 1'b0);
        resolve(32'h8000_0010, 3'b100, 1'b0, 1'b0, 1'b0);
        checks++; if (obs() !== 7'b0010000) begin errors++; $display("FAIL beq_not_taken: got %b want %b", obs(), 7'b0010000); end
        fetch(32'h8000_0010);
        checks++; if (obs() !== 7'b1000000) begin errors++; $display("FAIL sat_high_predict: got %b want %b", obs(), 7'b1000000); end
        checks++; if (bus.mispred_cnt !== 32'd2) begin errors++; $display("FAIL mcnt_after_train: got %0d want 2", bus.mispred_cnt); end
    endtask

    task automatic test_jump_none();
        resolve(32'h8000_0020, 3'b010, 1'b0, 1'b0, 1'b0);
        checks++; if (obs() !== 7'b0011111) begin errors++; $display("FAIL jalr: got %b want %b", obs(), 7'b0011111); end
        fetch(32'h8000_0020);
        checks++; if (obs() !== 7'b1000000) begin errors++; $display("FAIL jalr_table_untouched: got %b want %b", obs(), 7'b1000000); end
        resolve(32'h8000_0020, 3'b001, 1'b0, 1'b0, 1'b1);
        checks++; if (obs() !== 7'b0011100) begin errors++; $display("FAIL jal: got %b want %b", obs(), 7'b0011100); end
        resolve(32'h8000_0020, 3'b000, 1'b0, 1'b0, 1'b1);
        checks++; if (obs() !== 7'b0010001) begin errors++; $display("FAIL none_pred_taken: got %b want %b", obs(), 7'b0010001); end
        resolve(32'h8000_0020, 3'b011, 1'b1, 1'b1, 1'b0);
        checks++; if (obs() !== 7'b0010000) begin errors++; $display("FAIL code_011: got %b want %b", obs(), 7'b0010000); end
        checks++; if (bus.mispred_cnt !== model_mcnt) begin errors++; $display("FAIL mcnt_jumps: got %0d want %0d", bus.mispred_cnt, model_mcnt); end
    endtask

    task automatic test_saturate_collision();
        for (int i = 0; i < 3; i++) begin
            resolve(32'h8000_0030, 3'b111, 1'b1, 1'b0, 1'b0);
            checks++; if (obs() !== 7'b0010000) begin errors++; $display("FAIL bge_not_taken_%0d: got %b want %b", i, obs(), 7'b0010000); end
        end
        resolve(32'h8000_0030, 3'b111, 1'b0, 1'b0, 1'b0);
        checks++; if (obs() !== 7'b0011101) begin errors++; $display("FAIL bge_taken: got %b want %b", obs(), 7'b0011101); end
        fetch(32'h8000_0030);
        checks++; if (obs() !== 7'b1000000) begin errors++; $display("FAIL no_underflow: got %b want %b", obs(), 7'b1000000); end
        drive(1'b1, 32'h8000_0030, 1'b0, 1'b1, 32'h8000_0030, 3'b111, 1'b0, 1'b0, 1'b0);
        checks++; if (obs() !== 7'b1011101) begin errors++; $display("FAIL collision_read_old: got %b want %b", obs(), 7'b1011101); end
        fetch(32'h8000_0030);
        checks++; if (obs() !== 7'b1100000) begin errors++; $display("FAIL collision_committed: got %b want %b", obs(), 7'b1100000); end
    endtask

    task automatic test_flush_back_to_back();
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.p_valid !== 1'b0) begin errors++; $display("FAIL flush_same_cycle: got %b want 0", bus.p_valid); end
        fetch(32'h8000_0030);
        checks++; if (obs() !== 7'b1100000) begin errors++; $display("FAIL b2b_first: got %b want %b", obs(), 7'b1100000); end
        fetch(32'h8000_0000);
        checks++; if (obs() !== 7'b1000000) begin errors++; $display("FAIL b2b_second: got %b want %b", obs(), 7'b1000000); end
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0000, 3'b101, 1'b0, 1'b0, 1'b1);
        checks++; if (obs() !== 7'b0011100) begin errors++; $display("FAIL flush_clears_pvalid_keeps_resolve: got %b want %b", obs(), 7'b0011100); end
    endtask

    task automatic test_random();
        logic [31:0] fpc, rpc;
        for (int i = 0; i < 400; i++) begin
            fpc = 32'h8000_0000 + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 7) << 2);
            rpc = 32'h8000_0000 + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 7) << 2);
            drive(1'($urandom_range(0, 1)), fpc, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0), rpc, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++; if (obs() !== exp_vec) begin errors++; $display("FAIL random_outputs cycle %0d: got %b want %b", i, obs(), exp_vec); end
            checks++; if (bus.mispred_cnt !== model_mcnt) begin errors++; $display("FAIL random_mcnt cycle %0d: got %0d want %0d", i, bus.mispred_cnt, model_mcnt); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h8000_0040, 1'b0, 1'b1, 32'h8000_0040, 3'b100, 1'b0, 1'b1, 1'b0);
        checks++; if (obs() !== exp_vec) begin errors++; $display("FAIL pre_reset_busy: got %b want %b", obs(), exp_vec); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (obs() !== 7'b0) begin errors++; $display("FAIL async_reset_outputs: got %b want %b", obs(), 7'b0); end
        checks++; if (bus.mispred_cnt !== '0) begin errors++; $display("FAIL async_reset_mcnt: got %0d want 0", bus.mispred_cnt); end
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        checks++; if (obs() !== 7'b0) begin errors++; $display("FAIL post_reset_idle: got %b want %b", obs(), 7'b0); end
        fetch(32'h8000_0010);
        checks++; if (obs() !== 7'b1000000) begin errors++; $display("FAIL table_reset_predict: got %b want %b", obs(), 7'b1000000); end
        resolve(32'h8000_0010, 3'b100, 1'b0, 1'b1, 1'b1);
        fetch(32'h8000_0010);
        checks++; if (obs() !== 7'b1100000) begin errors++; $display("FAIL table_reset_weak: got %b want %b", obs(), 7'b1100000); end
    endtask

    initial begin
        test_reset();
        test_train();
        test_jump_none();
        test_saturate_collision();
        test_flush_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
